// File: rtl/signed_seq_divider_pkg.sv
// Shared ALU arithmetic definitions: sequencer state encoding for the divider.
package signed_seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/signed_seq_divider_div_step.sv
// One unsigned restoring division step: shift in a dividend bit, trial-subtract, keep or restore.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] rem,
    input  logic           dvd_bit,
    input  logic [WIDTH:0] dvs,
    output logic [WIDTH:0] rem_next,
    output logic           q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted  = {rem[WIDTH-1:0], dvd_bit};
        diff     = shifted - dvs;
        q_bit    = (shifted >= dvs);
        rem_next = q_bit ? diff : shifted;
    end

endmodule

// File: rtl/signed_seq_divider.sv
// Sequential signed divider: magnitudes divided by WIDTH restoring steps, signs applied in FIX.
module signed_seq_divider
    import signed_seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH:0]   dvs_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH:0]   rem_nxt;
    logic             q_bit;
    logic             a_neg, b_neg, b_zero, ovf_q;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // The most negative value maps onto itself, which read unsigned is exactly 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .dvs     (dvs_q),
        .rem_next(rem_nxt),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration, and sign fix-up; only visible results are cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q    <= A;
                    a_neg  <= A[WIDTH-1];
                    b_neg  <= B[WIDTH-1];
                    b_zero <= (B == '0);
                    ovf_q  <= (A == MIN_VAL) && (B == '1);
                    dvd_q  <= magnitude(A);
                    dvs_q  <= {1'b0, magnitude(B)};
                    rem_q  <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[WIDTH-2:0], q_bit};
                    dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX: begin
                    div_by_zero <= b_zero;
                    overflow    <= ovf_q;
                    if (b_zero) begin
                        Quotient  <= '1;
                        Remainder <= a_q;
                    end else begin
                        Quotient  <= (a_neg ^ b_neg) ? negate(quo_q) : quo_q;
                        Remainder <= a_neg ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_seq_divider.sv
// Self-checking bench for signed_seq_divider: directed table, corner sequences, random ops vs model.
module tb_signed_seq_divider;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B;
    logic [31:0] Quotient, Remainder;
    logic        busy, done, div_by_zero, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    signed_seq_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .A          (A),
        .B          (B),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b, q, r;
        logic        dz, ov;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division in 64 bits, truncating toward zero.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = (sb == 0);
        ov = (sa == -64'sd2147483648) && (sb == -1);
        if (dz) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else begin
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Drive a start for one cycle; returns at cycle 1 (just after the sampling edge).
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic [31:0] r,
                             input logic dz, input logic ov);
        int n;
        start_op(a, b);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(n);
        check({tag, " latency"}, 64'(n), 64'd34);
        check({tag, " Quotient"}, 64'(Quotient), 64'(q));
        check({tag, " Remainder"}, 64'(Remainder), 64'(r));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(dz));
        check({tag, " overflow"}, 64'(overflow), 64'(ov));
        @(posedge clk); #1;
        check({tag, " done pulse width"}, 64'(done), 64'd0);
        check({tag, " busy after done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n, dcount, dcyc;
        logic busy_after;
        logic [31:0] eq, er, held_q, held_r;
        logic edz, eov;

        vecs[0]  = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0};
        vecs[1]  = '{-32'sd100,    32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2]  = '{32'd100,      -32'sd7,      32'hFFFFFFF2, 32'd2,        1'b0, 1'b0};
        vecs[3]  = '{-32'sd100,    -32'sd7,      32'd14,       32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1'b0};
        vecs[5]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 1'b1};
        vecs[6]  = '{32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, 1'b0};
        vecs[7]  = '{32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 1'b0};
        vecs[8]  = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b0};
        vecs[9]  = '{32'd7,        32'd100,      32'd0,        32'd7,        1'b0, 1'b0};
        vecs[10] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[12] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 32'd0,        1'b0, 1'b0};
        vecs[13] = '{32'h80000000, 32'd7,        32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0, 1'b0};

        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset Quotient", 64'(Quotient), 64'd0);
        check("reset Remainder", 64'(Remainder), 64'd0);
        check("reset flags", 64'({div_by_zero, overflow}), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 14; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                      vecs[i].dz, vecs[i].ov);

        // Results hold while idle and through the CALC phase of the next operation.
        held_q = Quotient; held_r = Remainder;
        repeat (3) @(posedge clk);
        #1;
        check("idle hold Quotient", 64'(Quotient), 64'(vecs[13].q));
        start_op(32'd1000, 32'd10);
        while (n < 20) begin @(posedge clk); #1; n++; end
        check("calc hold Quotient", 64'(Quotient), 64'(held_q));
        check("calc hold Remainder", 64'(Remainder), 64'(held_r));
        wait_done(n);
        check("next op Quotient", 64'(Quotient), 64'd100);
        @(posedge clk); #1;

        // Reset in cycle 10 aborts the operation without a done pulse.
        start_op(32'd100, 32'd7);
        n = 1;
        while (n < 9) begin @(posedge clk); #1; n++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort Quotient", 64'(Quotient), 64'd0);
        check("abort Remainder", 64'(Remainder), 64'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("abort no done", 64'(dcount), 64'd0);
        run_check("after abort", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);

        // Start while busy is ignored; operands wander after acceptance.
        start_op(32'd100, 32'd7);
        n = 1; dcount = 0; dcyc = 0; busy_after = 1'b1;
        while (n < 45) begin
            if (done) begin dcount++; if (dcyc == 0) dcyc = n; end
            if (n == 35) busy_after = busy;
            if (n == 4) begin start = 1'b1; A = 32'd1; B = 32'd1; end
            @(posedge clk); #1;
            n++;
            start = 1'b0; A = $urandom; B = $urandom;
        end
        check("busy start done count", 64'(dcount), 64'd1);
        check("busy start done cycle", 64'(dcyc), 64'd34);
        check("busy start Quotient", 64'(Quotient), 64'd14);
        check("busy start busy low", 64'(busy_after), 64'd0);

        // Start presented only in the DONE cycle is not accepted.
        start_op(32'd20, 32'd3);
        wait_done(n);
        check("done-cycle reach", 64'(done), 64'd1);
        start = 1'b1; A = 32'd50; B = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        check("done-cycle start ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("done-cycle still idle", 64'(busy), 64'd0);
        check("done-cycle Quotient", 64'(Quotient), 64'd6);

        // Reset has priority over a simultaneous start.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; A = 32'd7; B = 32'd1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("reset over start", 64'(busy), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 300);
                2: rb = -$urandom_range(1, 300);
                default: rb = (i % 8 == 3) ? 32'd0 : 32'($urandom_range(0, 65535));
            endcase
            ref_div(ra, rb, eq, er, edz, eov);
            run_check($sformatf("rand%0d", i), ra, rb, eq, er, edz, eov);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_seq_divider.md
SIGNED_SEQ_DIVIDER -- requirements
Module: signed_seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand, quotient and remainder bit width.
REQ-002 SHALL have port clk  input  1  meaning single rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  meaning request division of A by B; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  meaning signed two's-complement dividend.
REQ-006 SHALL have port B  input  WIDTH  meaning signed two's-complement divisor.
REQ-007 SHALL have port Quotient  output  WIDTH  meaning signed quotient, truncated toward zero.
REQ-008 SHALL have port Remainder  output  WIDTH  meaning signed remainder, sign equal to dividend's sign (or zero).
REQ-009 SHALL have port busy  output  1  meaning high from the cycle after an accepted start until done.
REQ-010 SHALL have port done  output  1  meaning one-cycle pulse when Quotient/Remainder are valid.
REQ-011 SHALL have port div_by_zero  output  1  meaning B was zero for the completed operation.
REQ-012 SHALL have port overflow  output  1  meaning A = -2^(WIDTH-1) and B = -1 for the completed operation.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-014 IDLE: start=1 SHALL capture A, B, signs, and |A|, |B| into registers, clear iteration counter, go to CALC; start=0 stays IDLE.
REQ-015 CALC SHALL perform one unsigned restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL negate quotient if operand signs differ and negate remainder if A negative, register results, go to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-018 Latency SHALL be WIDTH+2 cycles from start-sampling edge to done high (34 for WIDTH=32).
REQ-019 Quotient, Remainder, div_by_zero, overflow SHALL hold their last values until the FIX of the next operation.
REQ-020 start while busy SHALL be ignored; no queuing.
REQ-021 start in the DONE cycle SHALL be ignored; a new start is accepted only in IDLE.
REQ-022 B = 0 SHALL yield Quotient = all ones, Remainder = A, div_by_zero=1, same latency.
REQ-023 A = -2^(WIDTH-1), B = -1 SHALL yield Quotient = -2^(WIDTH-1), Remainder = 0, overflow=1, same latency.
REQ-024 |A| of -2^(WIDTH-1) SHALL be handled as unsigned 2^(WIDTH-1) (WIDTH+1-bit internal partial remainder).
REQ-025 A or B changing after the accepting edge SHALL not affect the operation in progress.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, busy=0, done=0, Quotient=0, Remainder=0, div_by_zero=0, overflow=0, counter=0.
REQ-027 reset asserted mid-operation SHALL abort it with no done pulse; reset SHALL take priority over start.

Structure
REQ-028 State encoding constants (IDLE, CALC, FIX, DONE) SHALL live in the shared ALU arithmetic package.
REQ-029 Datapath SHALL be one module plus at most one sub-module, div_step (one combinational restoring step: shift, subtract, select, quotient bit).
REQ-030 No combinational path SHALL exist from A/B/start to any output.

Verification
REQ-031 A=100, B=7, start -> done at cycle 34, Quotient=14, Remainder=2, flags 0.
REQ-032 A=-100, B=7 -> Quotient=-14, Remainder=-2; A=100, B=-7 -> Quotient=-14, Remainder=2; A=-100, B=-7 -> Quotient=14, Remainder=-2.
REQ-033 A=5, B=0 -> Quotient=32'hFFFFFFFF, Remainder=5, div_by_zero=1, overflow=0.
REQ-034 A=32'h80000000, B=32'hFFFFFFFF -> Quotient=32'h80000000, Remainder=0, overflow=1; A=32'h80000000, B=2 -> Quotient=32'hC0000000, Remainder=0.
REQ-035 start with A=100, B=7, reset at cycle 10 -> no done, outputs 0, busy=0; subsequent start A=9, B=3 -> Quotient=3, Remainder=0.
REQ-036 start A=100, B=7, second start A=1, B=1 at cycle 5 -> single done at cycle 34 with Quotient=14; busy low next cycle.
